// File: rtl/pic10_pkg.sv
// Shared PIC10 definitions: instruction-cycle phase encoding, NOP word and default PC width.
// Also used by the execute stage and the pic10_ir bench.
package pic10_pkg;

  localparam logic [11:0] NOP_WORD         = 12'h000;
  localparam int          DEFAULT_PC_WIDTH = 9;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_phase_t;

  // The phase counter wraps Q4 -> Q1 naturally in two bits.
  function automatic q_phase_t next_phase(input q_phase_t p);
    return q_phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/pic10_pc.sv
// PIC10 program counter: async reset to the calibration vector, then load or
// wrap-around increment whenever the fetch sequencer enables it.
module pic10_pc
  import pic10_pkg::*;
#(
  parameter int                    PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = PC_WIDTH'(9'h1FF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [PC_WIDTH-1:0] pc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_VECTOR;
    end else if (en) begin
      pc_reg <= load ? target : pc_reg + PC_ONE;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/pic10_fetch.sv
// PIC10 instruction-fetch sequencer: Q1-Q4 phase counter, IR load strobe,
// NOP-insertion mux for jumps and skips, and the program counter.
module pic10_fetch
  import pic10_pkg::*;
#(
  parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(9'h1FF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] pc_target,
  input  logic                skip,
  input  logic [11:0]         rom_data,
  output logic [PC_WIDTH-1:0] prog_addr,
  output logic [11:0]         program_bus,
  output logic                load_ir_reg,
  output logic [1:0]          q_phase
);

  q_phase_t phase_reg;
  logic     flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg <= Q1;
    end else if (!halt) begin
      phase_reg <= next_phase(phase_reg);
    end
  end

  // Decoded from registered phase; halt gates it in the same cycle it rises.
  assign load_ir_reg = (phase_reg == Q4) && !halt;

  // A jump or skip discards the prefetched word; pc_load alone steers the PC,
  // so a simultaneous skip cannot add a second NOP.
  assign flush       = pc_load || skip;
  assign program_bus = (load_ir_reg && !flush) ? rom_data : NOP_WORD;
  assign q_phase     = phase_reg;

  pic10_pc #(
    .PC_WIDTH    (PC_WIDTH),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (load_ir_reg),
    .load  (pc_load),
    .target(pc_target),
    .pc    (prog_addr)
  );

endmodule

// File: tb/tb_pic10_fetch.sv
// Directed bench for pic10_fetch: table of instruction cycles plus hand-written
// halt and mid-cycle reset sequences against a behavioural ROM.
module tb_pic10_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        pc_load;
  logic [8:0]  pc_target;
  logic        skip;
  logic [11:0] rom_data;
  logic [8:0]  prog_addr;
  logic [11:0] program_bus;
  logic        load_ir_reg;
  logic [1:0]  q_phase;

  logic [11:0] rom [512];
  int          vec_count = 0;
  int          miscompares = 0;
  int          load_count = 0;
  int          snap;

  typedef struct {
    logic [8:0]  addr;
    logic        ld;
    logic        sk;
    logic [8:0]  tgt;
    logic [11:0] bus;
  } vec_t;

  vec_t tbl [18];

  pic10_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .skip       (skip),
    .rom_data   (rom_data),
    .prog_addr  (prog_addr),
    .program_bus(program_bus),
    .load_ir_reg(load_ir_reg),
    .q_phase    (q_phase)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[prog_addr];

  always @(posedge clk) begin
    if (load_ir_reg) load_count++;
  end

  task automatic chk(input string name, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ph, input int addr,
                         input int ld, input int bus);
    chk({tag, " q_phase"}, int'(q_phase), ph);
    chk({tag, " prog_addr"}, int'(prog_addr), addr);
    chk({tag, " load_ir_reg"}, int'(load_ir_reg), ld);
    chk({tag, " program_bus"}, int'(program_bus), bus);
  endtask

  initial begin
    for (int a = 0; a < 512; a++) rom[a] = 12'h800 | 12'(a);
    rom[9'h1FF] = 12'hC25;
    rom[9'h000] = 12'hABC;

    // addr, pc_load, skip, target, expected Q4 bus
    tbl[0]  = '{9'h1FF, 1'b0, 1'b0, 9'h000, 12'hC25};
    tbl[1]  = '{9'h000, 1'b0, 1'b0, 9'h000, 12'hABC};
    tbl[2]  = '{9'h001, 1'b0, 1'b0, 9'h000, 12'h801};
    tbl[3]  = '{9'h002, 1'b0, 1'b0, 9'h000, 12'h802};
    tbl[4]  = '{9'h003, 1'b0, 1'b0, 9'h000, 12'h803};
    tbl[5]  = '{9'h004, 1'b0, 1'b0, 9'h000, 12'h804};
    tbl[6]  = '{9'h005, 1'b1, 1'b0, 9'h040, 12'h000};
    tbl[7]  = '{9'h040, 1'b0, 1'b0, 9'h000, 12'h840};
    tbl[8]  = '{9'h041, 1'b1, 1'b0, 9'h00F, 12'h000};
    tbl[9]  = '{9'h00F, 1'b0, 1'b0, 9'h000, 12'h80F};
    tbl[10] = '{9'h010, 1'b0, 1'b1, 9'h000, 12'h000};
    tbl[11] = '{9'h011, 1'b0, 1'b0, 9'h000, 12'h811};
    tbl[12] = '{9'h012, 1'b1, 1'b1, 9'h100, 12'h000};
    tbl[13] = '{9'h100, 1'b0, 1'b0, 9'h000, 12'h900};
    tbl[14] = '{9'h101, 1'b1, 1'b0, 9'h1FE, 12'h000};
    tbl[15] = '{9'h1FE, 1'b0, 1'b0, 9'h000, 12'h9FE};
    tbl[16] = '{9'h1FF, 1'b0, 1'b0, 9'h000, 12'hC25};
    tbl[17] = '{9'h000, 1'b0, 1'b0, 9'h000, 12'hABC};

    reset = 1'b1; halt = 1'b0; pc_load = 1'b0; skip = 1'b0; pc_target = '0;
    #7;
    chk_all("reset", 0, 9'h1FF, 0, 12'h000);
    @(negedge clk);
    reset = 1'b0;

    // Q1-Q3 carry junk jump/skip requests that must be ignored.
    for (int i = 0; i < 18; i++) begin
      for (int ph = 0; ph < 4; ph++) begin
        if (ph < 3) begin
          pc_load = 1'b1; skip = 1'b1; pc_target = 9'($urandom);
        end else begin
          pc_load = tbl[i].ld; skip = tbl[i].sk; pc_target = tbl[i].tgt;
        end
        #1;
        chk_all($sformatf("cyc%0d Q%0d", i, ph + 1), ph, int'(tbl[i].addr),
                (ph == 3) ? 1 : 0, (ph == 3) ? int'(tbl[i].bus) : 0);
        $display("cycle %0d Q%0d addr=%03h load=%0b bus=%03h", i, ph + 1,
                 prog_addr, load_ir_reg, program_bus);
        @(negedge clk);
      end
    end
    pc_load = 1'b0; skip = 1'b0; pc_target = '0;

    // Halt raised in Q4 of the cycle fetching 001, held for 10 clocks.
    repeat (3) @(negedge clk);
    snap = load_count;
    halt = 1'b1;
    #1;
    chk_all("halt entry", 3, 9'h001, 0, 12'h000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_all($sformatf("halt clk%0d", k), 3, 9'h001, 0, 12'h000);
    end
    halt = 1'b0;
    #1;
    chk_all("halt release", 3, 9'h001, 1, 12'h801);
    @(negedge clk);
    chk_all("after halt", 0, 9'h002, 0, 12'h000);
    chk("halt load count", load_count - snap, 1);
    $display("halt sequence done, loads=%0d", load_count - snap);

    // Reset asserted mid-Q3 across the edge that would have ended it.
    repeat (2) @(negedge clk);
    chk("pre-reset phase", int'(q_phase), 2);
    snap = load_count;
    reset = 1'b1;
    #1;
    chk_all("reset mid-Q3", 0, 9'h1FF, 0, 12'h000);
    @(negedge clk);
    chk_all("reset held", 0, 9'h1FF, 0, 12'h000);
    chk("reset no load", load_count - snap, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all("restart Q4", 3, 9'h1FF, 1, 12'hC25);
    @(negedge clk);
    chk_all("restart next", 0, 9'h000, 0, 12'h000);
    $display("reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/pic10_fetch.md
# pic10_fetch

Instruction-fetch sequencer for the PIC10 core, on the write side of the instruction register `pic10_ir`. It owns the program counter and the four-phase Q1–Q4 instruction cycle, and addresses program ROM. Once per instruction cycle it drives `program_bus` and pulses `load_ir_reg` so `pic10_ir` captures the next word. It inserts NOP (12'h000) words when the execute stage redirects the PC or requests a skip.

## Interface
- `PC_WIDTH`, default 9: program counter / ROM address width.
- `RESET_VECTOR`, default 9'h1FF: PC value after reset, which is the PIC10 calibration word location.
- `clk`  in  1: single clock; all state changes on posedge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `halt`  in  1: freezes the sequencer (sleep); sampled on every posedge.
- `pc_load`  in  1: execute requests a jump (GOTO/CALL/RETLW/PCL write); sampled only in Q4.
- `pc_target`  in  PC_WIDTH: jump destination; sampled with `pc_load`.
- `skip`  in  1: execute requests skip of the prefetched word; sampled only in Q4.
- `rom_data`  in  12: ROM word at `prog_addr`; must be valid by the posedge that ends Q4.
- `prog_addr`  out  PC_WIDTH: current PC, stable Q1–Q4.
- `program_bus`  out  12: word for `pic10_ir`; 12'h000 whenever `load_ir_reg`=0.
- `load_ir_reg`  out  1: high during Q4 only; `pic10_ir` loads on the posedge ending Q4.
- `q_phase`  out  2: 0=Q1, 1=Q2, 2=Q3, 3=Q4; used by the execute stage.

## Operation
- **Phase counter.** `q_phase` advances Q1→Q2→Q3→Q4→Q1, one step per posedge, when `halt`=0.
- **Halt.** With `halt`=1 the phase and the PC hold, and `load_ir_reg` is forced to 0.
- **Load strobe.** `load_ir_reg` = (`q_phase`==Q4) & ~`halt`. This is a combinational decode of registered state, so it is glitch-free.
- **Flush.** Flush = `pc_load` | `skip`, evaluated in Q4. When flush=1, `program_bus` = 12'h000 (NOP). Otherwise `program_bus` = `rom_data`.
- **PC update**, on the posedge ending Q4 with `halt`=0, in priority order:
  - `pc_load` → `pc_target`.
  - Otherwise → PC+1, modulo 2^PC_WIDTH. `skip` does not alter the PC.
- **Simultaneous `pc_load` and `skip`.** `pc_load` wins; one NOP is inserted, not two.
- **Outside Q4.** `pc_load`, `skip` and `pc_target` are ignored in Q1–Q3.
- **Two-cycle instructions.** Any jump yields exactly one NOP instruction cycle before the target word loads.

## Timing
- **Reset values:**
  - `q_phase`=Q1.
  - `prog_addr`=RESET_VECTOR.
  - `load_ir_reg`=0.
  - `program_bus`=12'h000.
- **Reset mid-cycle.** Assertion at any phase returns all outputs to reset values immediately. No partial load reaches `pic10_ir`.
- **After reset release:**
  - Posedges 1–3 step Q1→Q4.
  - During Q4, `load_ir_reg`=1 and `program_bus`=`rom_data` at RESET_VECTOR.
  - Posedge 4: IR holds that word, PC=RESET_VECTOR+1 (wraps to 0 at default), phase=Q1.
- **Throughput.** One instruction word per 4 clocks. Fetch-to-IR latency is 4 clocks from PC change.
- **Halt timing.** `halt` rising during Q4 suppresses that cycle's load in the same cycle. Deasserting resumes from the held phase with no word lost or duplicated.
- **Wrap-around.** PC=2^PC_WIDTH−1 increments to 0. The `pc_target` value is loaded unmodified.

## Structure
- **Shared package `pic10_pkg`:**
  - NOP word constant (12'h000).
  - Q-phase encodings Q1..Q4.
  - Default PC width.
  - Reuse from the execute stage and `pic10_ir` bench.
- **Sub-module `pic10_pc`:** PC register with async reset to RESET_VECTOR, load, increment and enable.
- **Top level:** `pic10_fetch` holds the phase counter, flush mux and strobe decode.

## Test plan
- **Reset/startup.** Assert `reset` 0–10 ns, ROM[1FF]=12'hC25, ROM[000]=12'hABC. Required:
  - During reset: `prog_addr`=1FF, `program_bus`=000, `load_ir_reg`=0.
  - The IR sees 12'hC25 at the 4th posedge.
  - The IR sees 12'hABC 4 clocks later.
  - `prog_addr` then =001.
- **Jump.** `pc_load`=1 with `pc_target`=9'h040 in Q4 of the cycle fetching address 005. Required:
  - `program_bus`=000 with `load_ir_reg`=1 that Q4.
  - `prog_addr`=040 next Q1.
  - The IR gets ROM[040] one cycle later.
- **Skip.** `skip`=1 in Q4 at `prog_addr`=010. Required: NOP loaded instead of ROM[010], `prog_addr`=011 next.
- **Simultaneous.** `pc_load`=1, `pc_target`=9'h100 and `skip`=1 in the same Q4. Required: exactly one NOP, then ROM[100].
- **Halt.** Raise `halt` in Q4 for 10 clocks. Required:
  - `load_ir_reg`=0 throughout; `q_phase` and `prog_addr` frozen.
  - After release, exactly one load of the held word.
- **Reset mid-Q3.** Required: immediate return to `q_phase`=Q1, `prog_addr`=1FF; no `load_ir_reg` pulse.
